// File: rtl/feature_map_writer_pkg.sv
// Shared network constants for the feature-map writer and related stages.
package feature_map_writer_pkg;

  localparam int unsigned NP_X_COORD_MAX   = 27;
  localparam int unsigned NP_Y_COORD_MAX   = 27;
  localparam int unsigned NP_X_COORD_WIDTH = 5;
  localparam int unsigned NP_Y_COORD_WIDTH = 5;
  localparam int unsigned NP_ADDR_WIDTH    = 10;
  localparam int unsigned NP_ACC_WIDTH     = 32;
  localparam int unsigned NP_OUT_WIDTH     = 16;
  localparam int unsigned NP_SHIFT         = 8;
  localparam bit          NP_RELU_EN       = 1'b1;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic shift, optional ReLU, signed saturation.
module requant_sat #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 8,
  parameter bit          RELU_EN   = 1'b1
) (
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic signed [OUT_WIDTH-1:0] out_data_c,
  output logic                        sat_c
);

  localparam logic signed [IN_WIDTH-1:0] MAX_VAL =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_VAL =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0] shifted;
  logic signed [IN_WIDTH-1:0] clamped;

  // Shift, clamp negatives under ReLU (not a saturation), then saturate to OUT_WIDTH.
  always_comb begin
    shifted = in_data >>> SHIFT;
    clamped = shifted;
    sat_c   = 1'b0;
    if (RELU_EN && shifted[IN_WIDTH-1]) begin
      clamped = '0;
    end else if (shifted > MAX_VAL) begin
      clamped = MAX_VAL;
      sat_c   = 1'b1;
    end else if (shifted < MIN_VAL) begin
      clamped = MIN_VAL;
      sat_c   = 1'b1;
    end
    out_data_c = OUT_WIDTH'(clamped);
  end

endmodule

// File: rtl/feature_map_writer.sv
// Output feature-map writer: raster position tracking, requantization and RAM write port.
module feature_map_writer
  import feature_map_writer_pkg::*;
#(
  parameter int unsigned X_COORD_MAX   = NP_X_COORD_MAX,
  parameter int unsigned Y_COORD_MAX   = NP_Y_COORD_MAX,
  parameter int unsigned X_COORD_WIDTH = NP_X_COORD_WIDTH,
  parameter int unsigned Y_COORD_WIDTH = NP_Y_COORD_WIDTH,
  parameter int unsigned ADDR_WIDTH    = NP_ADDR_WIDTH,
  parameter int unsigned ACC_WIDTH     = NP_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH     = NP_OUT_WIDTH,
  parameter int unsigned SHIFT         = NP_SHIFT,
  parameter bit          RELU_EN       = NP_RELU_EN
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        pixel_rdy,
  input  logic signed [ACC_WIDTH-1:0] acc_data,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [OUT_WIDTH-1:0]        wr_data,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        sat_flag,
  output logic                        err_flag
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [X_COORD_WIDTH-1:0] X_LAST = X_COORD_WIDTH'(X_COORD_MAX);
  localparam logic [Y_COORD_WIDTH-1:0] Y_LAST = Y_COORD_WIDTH'(Y_COORD_MAX);

  state_e                 state_q, state_d;
  logic [X_COORD_WIDTH-1:0] x_q, x_d;
  logic [Y_COORD_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [OUT_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   sat_flag_q, sat_flag_d;
  logic                   err_flag_q, err_flag_d;

  logic signed [OUT_WIDTH-1:0] q_data_c;
  logic                        q_sat_c;

  requant_sat #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT),
    .RELU_EN  (RELU_EN)
  ) u_requant_sat (
    .in_data   (acc_data),
    .out_data_c(q_data_c),
    .sat_c     (q_sat_c)
  );

  // State and output registers; reset drops everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sat_flag_q   <= 1'b0;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      sat_flag_q   <= sat_flag_d;
      err_flag_q   <= err_flag_d;
    end
  end

  // Next-state: frame arming, pixel acceptance with raster advance, sticky flags.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    sat_flag_d   = sat_flag_q;
    err_flag_d   = err_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ACTIVE;
          x_d        = '0;
          y_d        = '0;
          addr_d     = '0;
          sat_flag_d = 1'b0;
          err_flag_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (pixel_rdy) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = q_data_c;
          if (q_sat_c) sat_flag_d = 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d          = '0;
              addr_d       = '0;
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
            end else begin
              y_d    = y_q + Y_COORD_WIDTH'(1);
              addr_d = addr_q + ADDR_WIDTH'(1);
            end
          end else begin
            x_d    = x_q + X_COORD_WIDTH'(1);
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A pixel outside ACTIVE is a protocol error, even alongside an arming start.
    if (pixel_rdy && (state_q != ST_ACTIVE)) err_flag_d = 1'b1;

    busy_d = (state_d == ST_ACTIVE);
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sat_flag   = sat_flag_q;
  assign err_flag   = err_flag_q;

endmodule
